// File: rtl/picosoc_gpio_pkg.sv
// Shared constants for the PicoSoC GPIO peripheral: register word offsets, default page, strobe helper.
package picosoc_gpio_pkg;

    localparam logic [7:0] GPIO_BASE_PAGE = 8'h03;

    // Word indices as decoded from iomem_addr[4:2]
    localparam logic [2:0] GPIO_OFF_OUT  = 3'd0;
    localparam logic [2:0] GPIO_OFF_OE   = 3'd1;
    localparam logic [2:0] GPIO_OFF_IN   = 3'd2;
    localparam logic [2:0] GPIO_OFF_MASK = 3'd3;
    localparam logic [2:0] GPIO_OFF_EDGE = 3'd4;
    localparam logic [2:0] GPIO_OFF_STAT = 3'd5;
    localparam logic [2:0] GPIO_OFF_SET  = 3'd6;
    localparam logic [2:0] GPIO_OFF_CLR  = 3'd7;

    function automatic logic [31:0] gpio_strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/picosoc_gpio_ctrl_debounce.sv
// Single-channel debouncer: output follows the input only after it has held a new value
// for DEBOUNCE_CYCLES consecutive cycles.
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_bufg,
    input  logic resetn,
    input  logic i_d,
    output logic o_q
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_q;

    always_ff @(posedge clk_bufg) begin
        if (!resetn) begin
            r_cnt <= '0;
            r_q   <= 1'b0;
        end else if (i_d == r_q) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_q   <= i_d;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/picosoc_gpio_ctrl.sv
// iomem-mapped N-channel GPIO with set/clear, synchronised inputs and edge interrupts.
// Define GPIO_DEBOUNCE_EN to insert a per-channel debouncer after the synchroniser.
module picosoc_gpio_ctrl
    import picosoc_gpio_pkg::*;
#(
    parameter int          N_GPIO          = 32,
    parameter logic [7:0]  BASE_PAGE       = GPIO_BASE_PAGE,
    parameter logic [31:0] OUT_RESET       = 32'h0,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic              clk_bufg,
    input  logic              resetn,
    input  logic              iomem_valid,
    output logic              iomem_ready,
    input  logic [3:0]        iomem_wstrb,
    input  logic [31:0]       iomem_addr,
    input  logic [31:0]       iomem_wdata,
    output logic [31:0]       iomem_rdata,
    input  logic [N_GPIO-1:0] gpio_in,
    output logic [N_GPIO-1:0] gpio_out,
    output logic [N_GPIO-1:0] gpio_oe,
    output logic              irq
);
    logic              r_ready, r_irq;
    logic [31:0]       r_rdata;
    logic [N_GPIO-1:0] r_out, r_oe, r_mask, r_edge, r_stat;
    logic [N_GPIO-1:0] r_sync1, r_sync2, r_prev;

    logic              w_sel, w_wr;
    logic [2:0]        w_idx;
    logic [31:0]       w_mask_full;
    logic [N_GPIO-1:0] w_wbits, w_w1c, w_ev, w_in_q, w_rd;
    logic              w_unused;

    assign w_sel       = iomem_valid && !r_ready && (iomem_addr[31:24] == BASE_PAGE);
    assign w_wr        = w_sel && (iomem_wstrb != 4'b0000);
    assign w_idx       = iomem_addr[4:2];
    assign w_mask_full = gpio_strb_mask(iomem_wstrb);
    assign w_wbits     = iomem_wdata[N_GPIO-1:0] & w_mask_full[N_GPIO-1:0];
    assign w_w1c       = (w_wr && w_idx == GPIO_OFF_STAT) ? w_wbits : '0;
    assign w_unused    = ^{iomem_addr[23:5], iomem_addr[1:0]};

`ifdef GPIO_DEBOUNCE_EN
    generate
        for (genvar gi = 0; gi < N_GPIO; gi++) begin : g_db
            gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clk_bufg (clk_bufg),
                .resetn   (resetn),
                .i_d      (r_sync2[gi]),
                .o_q      (w_in_q[gi])
            );
        end
    endgenerate
`else
    assign w_in_q = r_sync2;
`endif

    // Per-bit polarity select; prev tracks in_q so an IRQ_EDGE change alone raises nothing
    assign w_ev = (r_edge & w_in_q & ~r_prev) | (~r_edge & ~w_in_q & r_prev);

    always_comb begin
        w_rd = '0;
        case (w_idx)
            GPIO_OFF_OUT:  w_rd = r_out;
            GPIO_OFF_OE:   w_rd = r_oe;
            GPIO_OFF_IN:   w_rd = w_in_q;
            GPIO_OFF_MASK: w_rd = r_mask;
            GPIO_OFF_EDGE: w_rd = r_edge;
            GPIO_OFF_STAT: w_rd = r_stat;
            default:       w_rd = '0;
        endcase
    end

    always_ff @(posedge clk_bufg) begin
        if (!resetn) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
            r_out   <= OUT_RESET[N_GPIO-1:0];
            r_oe    <= '0;
            r_mask  <= '0;
            r_edge  <= '0;
            r_stat  <= '0;
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_ready <= w_sel;
            if (w_sel)
                r_rdata <= 32'(w_rd);
            if (w_wr) begin
                case (w_idx)
                    GPIO_OFF_OUT:  r_out  <= (r_out  & ~w_mask_full[N_GPIO-1:0]) | w_wbits;
                    GPIO_OFF_OE:   r_oe   <= (r_oe   & ~w_mask_full[N_GPIO-1:0]) | w_wbits;
                    GPIO_OFF_MASK: r_mask <= (r_mask & ~w_mask_full[N_GPIO-1:0]) | w_wbits;
                    GPIO_OFF_EDGE: r_edge <= (r_edge & ~w_mask_full[N_GPIO-1:0]) | w_wbits;
                    GPIO_OFF_SET:  r_out  <= r_out | w_wbits;
                    GPIO_OFF_CLR:  r_out  <= r_out & ~w_wbits;
                    default: ;
                endcase
            end
            // New events override a same-cycle W1C
            r_stat  <= (r_stat & ~w_w1c) | w_ev;
            r_irq   <= |(r_stat & r_mask);
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            r_prev  <= w_in_q;
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign gpio_out    = r_out;
    assign gpio_oe     = r_oe;
    assign irq         = r_irq;

endmodule

// File: tb/tb_picosoc_gpio_ctrl.sv
// Directed self-checking bench for picosoc_gpio_ctrl; read data checked through an expectation queue.
module tb_picosoc_gpio_ctrl;
    localparam int DB = 16;
`ifdef GPIO_DEBOUNCE_EN
    localparam int IN_LAT = 2 + DB;
`else
    localparam int IN_LAT = 2;
`endif
    localparam logic [31:0] A_OUT  = 32'h0300_0000, A_OE   = 32'h0300_0004;
    localparam logic [31:0] A_IN   = 32'h0300_0008, A_MASK = 32'h0300_000C;
    localparam logic [31:0] A_EDGE = 32'h0300_0010, A_STAT = 32'h0300_0014;
    localparam logic [31:0] A_SET  = 32'h0300_0018, A_CLR  = 32'h0300_001C;

    logic        clk_bufg = 1'b0;
    logic        resetn;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;
    logic [31:0] gpio_in, gpio_out, gpio_oe;
    logic        irq;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk_bufg = ~clk_bufg;

    picosoc_gpio_ctrl #(.N_GPIO(32), .DEBOUNCE_CYCLES(DB)) dut (
        .clk_bufg    (clk_bufg),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .gpio_oe     (gpio_oe),
        .irq         (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One transfer; ack must come exactly one cycle after the request. Reads pop an expectation.
    task automatic bus(input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata, input string tag);
        int n;
        logic [31:0] e;
        @(negedge clk_bufg);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = wdata;
        n = 0;
        do begin
            @(negedge clk_bufg);
            n++;
        end while (!iomem_ready && n < 20);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        check({tag, " ack latency"}, 32'(n), 32'd1);
        if (strb == 4'b0000 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, iomem_rdata, e);
        end
        $display("txn %s addr=0x%08h wstrb=%b wdata=0x%08h rdata=0x%08h", tag, addr, strb, wdata, iomem_rdata);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        bus(addr, 4'b0000, 32'h0, tag);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] strb,
                      input logic [31:0] wdata, input string tag);
        bus(addr, strb, wdata, tag);
    endtask

    initial begin
        int seen;
        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        iomem_addr  = '0;
        iomem_wdata = '0;
        gpio_in     = '0;
        repeat (3) @(negedge clk_bufg);
        check("reset gpio_out", gpio_out, 32'h0);
        check("reset gpio_oe", gpio_oe, 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        check("reset ready", 32'(iomem_ready), 32'h0);
        check("reset rdata", iomem_rdata, 32'h0);
        resetn = 1'b1;

        // Partial-strobe write, single-cycle ack
        wr(A_OUT, 4'b0011, 32'hA5A5_5A5A, "out_lo");
        @(negedge clk_bufg);
        check("ready one cycle", 32'(iomem_ready), 32'h0);
        rd(A_OUT, 32'h0000_5A5A, "out_rb");
        check("gpio_out strobed", gpio_out, 32'h0000_5A5A);

        // Set / clear
        wr(A_OUT, 4'b1111, 32'h0000_000F, "out_0f");
        wr(A_SET, 4'b1111, 32'h0000_00F0, "set_f0");
        wr(A_CLR, 4'b1111, 32'h0000_0003, "clr_03");
        check("gpio_out set/clr", gpio_out, 32'h0000_00FC);
        rd(A_SET, 32'h0, "set_rd0");
        rd(A_CLR, 32'h0, "clr_rd0");
        wr(A_SET, 4'b0010, 32'hFFFF_FFFF, "set_byte1");
        check("gpio_out set strobed", gpio_out, 32'h0000_FFFC);
        wr(A_CLR, 4'b0010, 32'hFFFF_FFFF, "clr_byte1");
        check("gpio_out clr strobed", gpio_out, 32'h0000_00FC);

        wr(A_OE, 4'b1111, 32'h1234_8001, "oe");
        check("gpio_oe", gpio_oe, 32'h1234_8001);
        rd(A_OE, 32'h1234_8001, "oe_rb");
        wr(A_IN, 4'b1111, 32'hFFFF_FFFF, "in_wr");
        rd(A_IN, 32'h0, "in_rd0");

        // Foreign page never acknowledged
        @(negedge clk_bufg);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0200_0000;
        iomem_wstrb = 4'b1111;
        iomem_wdata = 32'hFFFF_FFFF;
        seen = 0;
        repeat (10) begin
            @(negedge clk_bufg);
            if (iomem_ready) seen++;
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        check("foreign page ack", 32'(seen), 32'h0);
        rd(A_OUT, 32'h0000_00FC, "out_after_foreign");

        // Rising-edge interrupt on bit 0 with exact latency
        wr(A_MASK, 4'b1111, 32'h1, "mask");
        wr(A_EDGE, 4'b1111, 32'h1, "edge_rise");
        @(negedge clk_bufg);
        gpio_in[0] = 1'b1;
        repeat (IN_LAT + 1) @(negedge clk_bufg);
        check("irq not yet", 32'(irq), 32'h0);
        @(negedge clk_bufg);
        check("irq raised", 32'(irq), 32'h1);
        rd(A_STAT, 32'h1, "stat_rise");
        rd(A_IN, 32'h1, "in_bit0");
        wr(A_STAT, 4'b0010, 32'h0000_0101, "w1c_wrong_lane");
        rd(A_STAT, 32'h1, "stat_kept");
        wr(A_STAT, 4'b1111, 32'h1, "w1c");
        check("irq holds one cycle", 32'(irq), 32'h1);
        @(negedge clk_bufg);
        check("irq dropped", 32'(irq), 32'h0);

        // Falling edge while rise-sensitive: no event
        gpio_in[0] = 1'b0;
        repeat (IN_LAT + 4) @(negedge clk_bufg);
        rd(A_STAT, 32'h0, "stat_fall_ignored");
        check("irq after fall", 32'(irq), 32'h0);

        // W1C lands on the same edge as a new rise: set wins
        gpio_in[0] = 1'b1;
        repeat (IN_LAT) @(negedge clk_bufg);
        iomem_valid = 1'b1;
        iomem_addr  = A_STAT;
        iomem_wstrb = 4'b1111;
        iomem_wdata = 32'h1;
        @(negedge clk_bufg);
        check("collide ack", 32'(iomem_ready), 32'h1);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        rd(A_STAT, 32'h1, "stat_set_wins");
        wr(A_STAT, 4'b1111, 32'h1, "w1c2");
        rd(A_STAT, 32'h0, "stat_cleared");

        // Polarity change alone raises nothing; a fall then does
        wr(A_EDGE, 4'b1111, 32'h0, "edge_fall");
        rd(A_STAT, 32'h0, "stat_edge_change");
        gpio_in[0] = 1'b0;
        repeat (IN_LAT + 4) @(negedge clk_bufg);
        rd(A_STAT, 32'h1, "stat_fall_event");
        check("irq on fall", 32'(irq), 32'h1);
        wr(A_STAT, 4'b1111, 32'h1, "w1c3");

`ifdef GPIO_DEBOUNCE_EN
        wr(A_EDGE, 4'b1111, 32'h2, "edge_b1");
        @(negedge clk_bufg);
        gpio_in[1] = 1'b1;
        repeat (10) @(negedge clk_bufg);
        gpio_in[1] = 1'b0;
        repeat (30) @(negedge clk_bufg);
        rd(A_IN, 32'h0, "db_short_in");
        rd(A_STAT, 32'h0, "db_short_stat");
        gpio_in[1] = 1'b1;
        repeat (14) @(negedge clk_bufg);
        rd(A_IN, 32'h0, "db_long_early");
        repeat (2) @(negedge clk_bufg);
        rd(A_IN, 32'h2, "db_long_in");
        gpio_in[1] = 1'b0;
        rd(A_STAT, 32'h2, "db_long_stat");
`endif

        check("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
